// File: rtl/sram_model.sv
// sram_model: cycle-based model of the 256Kx16 async SRAM behind SRAM_CTRL.
// Define SRAM_PROTOCOL_CHECK_EN to flag controller timing violations.
module sram_model #(
    parameter int ADDR_WIDTH   = 18,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] SRAM_DQ,
    input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    input  logic                  SRAM_UB_N,
    input  logic                  SRAM_LB_N,
    input  logic                  SRAM_WE_N,
    input  logic                  SRAM_CE_N,
    input  logic                  SRAM_OE_N,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic                  busy,
    output logic                  violation
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_VALID,
        WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              lane_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

    logic wr_req, rd_req, addr_chg, lane_chg;
    logic commit, count_wr, count_rd;
    logic drive, hi_on, lo_on;
    logic [15:0] rdata;

    always_comb begin
        wr_req   = !SRAM_CE_N && !SRAM_WE_N;
        rd_req   = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
        addr_chg = SRAM_ADDR != addr_q;
        lane_chg = {SRAM_UB_N, SRAM_LB_N} != lane_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        count_wr = 1'b0;
        count_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_req) begin
                    commit   = 1'b1;
                    count_wr = 1'b1;
                    state_d  = WRITE;
                end else if (rd_req) begin
                    state_d = READ_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WRITE: begin
                if (wr_req) begin
                    commit   = 1'b1;
                    count_wr = addr_chg;
                end else begin
                    state_d = IDLE;
                end
            end
            READ_WAIT: begin
                if (!rd_req) begin
                    state_d = IDLE;
                end else if (addr_chg || lane_chg) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d  = READ_VALID;
                    count_rd = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            READ_VALID: begin
                if (wr_req) begin
                    commit   = 1'b1;
                    count_wr = 1'b1;
                    state_d  = WRITE;
                end else if (!rd_req) begin
                    state_d = IDLE;
                end else if (addr_chg) begin
                    state_d = READ_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory contents survive reset; only the access in flight is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            lane_q   <= 2'b11;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= SRAM_ADDR;
            lane_q  <= {SRAM_UB_N, SRAM_LB_N};
            if (count_rd) rd_count <= rd_count + 32'd1;
            if (count_wr) wr_count <= wr_count + 32'd1;
            if (commit && !SRAM_UB_N)
                mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
            if (commit && !SRAM_LB_N)
                mem[SRAM_ADDR][7:0] <= SRAM_DQ[7:0];
        end
    end

    // Drive follows the live pins so a write request releases the bus at once.
    always_comb begin
        drive = rd_req && (state_q == READ_WAIT || state_q == READ_VALID);
        hi_on = drive && !SRAM_UB_N;
        lo_on = drive && !SRAM_LB_N;
        rdata = (state_q == READ_VALID) ? mem[addr_q] : 'x;
    end

    assign SRAM_DQ[15:8] = hi_on ? rdata[15:8] : 8'bz;
    assign SRAM_DQ[7:0]  = lo_on ? rdata[7:0]  : 8'bz;
    assign busy          = state_q == READ_WAIT;

`ifdef SRAM_PROTOCOL_CHECK_EN
    logic bad_wait, bad_lane, bad_both;

    always_comb begin
        bad_wait = state_q == READ_WAIT && rd_req && (addr_chg || lane_chg);
        bad_lane = wr_req && SRAM_UB_N && SRAM_LB_N;
        bad_both = !SRAM_WE_N && !SRAM_OE_N;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            violation <= 1'b0;
        end else begin
            if (bad_wait || bad_lane || bad_both) violation <= 1'b1;
            if (bad_wait) $display("%0t sram_model: addr/lane change in READ_WAIT", $time);
            if (bad_lane) $display("%0t sram_model: write with no byte lane", $time);
            if (bad_both) $display("%0t sram_model: WE_N and OE_N both low", $time);
        end
    end
`else
    assign violation = 1'b0;
`endif

endmodule

// File: tb/tb_sram_model.sv
// tb_sram_model: directed and random checks of sram_model against a
// transaction-level memory model; high-Z bus lanes read as 1 via tri1.
module tb_sram_model;
    localparam int AW = 18;
    localparam int RL = 2;
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_VALID = 2;
    localparam int M_WRITE = 3;
`ifdef SRAM_PROTOCOL_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tri1 [15:0] dq;
    logic [AW-1:0] addr = '0;
    logic ub_n = 1'b1, lb_n = 1'b1, we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
    logic [15:0] wdata = '0;
    logic [31:0] rd_count, wr_count;
    logic busy, violation;
    int total = 0;
    int bad = 0;

    assign dq = we_n ? 16'hzzzz : wdata;

    sram_model #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(16),
        .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SRAM_DQ(dq),
        .SRAM_ADDR(addr),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n),
        .SRAM_WE_N(we_n),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n),
        .rd_count(rd_count),
        .wr_count(wr_count),
        .busy(busy),
        .violation(violation)
    );

    // reference model: access mode, edges left until data, sampled pins
    int mode, left;
    logic [AW-1:0] p_addr;
    logic p_ub, p_lb, m_viol;
    int unsigned m_rd, m_wr;
    logic [15:0] mm [int];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_at(input logic [AW-1:0] a);
        return mm.exists(int'(a)) ? mm[int'(a)] : 16'h0000;
    endfunction

    task automatic model_reset();
        mode = M_IDLE;
        left = 0;
        m_rd = 0;
        m_wr = 0;
        m_viol = 1'b0;
        p_addr = '0;
        p_ub = 1'b1;
        p_lb = 1'b1;
    endtask

    task automatic model_commit();
        logic [15:0] v;
        v = mem_at(addr);
        if (!ub_n) v[15:8] = wdata[15:8];
        if (!lb_n) v[7:0] = wdata[7:0];
        mm[int'(addr)] = v;
    endtask

    task automatic model_edge();
        logic wr, rd, achg, lchg;
        wr = !ce_n && !we_n;
        rd = !ce_n && we_n && !oe_n;
        achg = addr != p_addr;
        lchg = (ub_n != p_ub) || (lb_n != p_lb);
        if (CHECK_ON) begin
            if (mode == M_WAIT && rd && (achg || lchg)) m_viol = 1'b1;
            if (wr && ub_n && lb_n) m_viol = 1'b1;
            if (!we_n && !oe_n) m_viol = 1'b1;
        end
        case (mode)
            M_IDLE: begin
                if (wr) begin
                    model_commit();
                    m_wr++;
                    mode = M_WRITE;
                end else if (rd) begin
                    mode = M_WAIT;
                    left = RL;
                end
            end
            M_WRITE: begin
                if (wr) begin
                    model_commit();
                    if (achg) m_wr++;
                end else begin
                    mode = M_IDLE;
                end
            end
            M_WAIT: begin
                if (!rd) begin
                    mode = M_IDLE;
                end else if (achg || lchg) begin
                    left = RL;
                end else begin
                    left--;
                    if (left == 0) begin
                        mode = M_VALID;
                        m_rd++;
                    end
                end
            end
            default: begin
                if (wr) begin
                    model_commit();
                    m_wr++;
                    mode = M_WRITE;
                end else if (!rd) begin
                    mode = M_IDLE;
                end else if (achg) begin
                    mode = M_WAIT;
                    left = RL;
                end
            end
        endcase
        p_addr = addr;
        p_ub = ub_n;
        p_lb = lb_n;
    endtask

    task automatic check_dq(input string tag);
        logic [15:0] e, m, v;
        logic rdl;
        rdl = !ce_n && we_n && !oe_n;
        e = 16'hFFFF;
        m = 16'h0000;
        v = mem_at(p_addr);
        if (!we_n) begin
            e = wdata;
        end else if (rdl && mode == M_VALID) begin
            if (!ub_n) e[15:8] = v[15:8];
            if (!lb_n) e[7:0] = v[7:0];
        end else if (rdl && mode == M_WAIT) begin
            if (!ub_n) m[15:8] = 8'hFF;
            if (!lb_n) m[7:0] = 8'hFF;
        end
        chk(tag, 32'(dq | m), 32'(e | m));
    endtask

    task automatic check_all(input string tag);
        check_dq({tag, "_dq"});
        chk({tag, "_busy"}, 32'(busy), 32'(mode == M_WAIT));
        chk({tag, "_rdc"}, rd_count, 32'(m_rd));
        chk({tag, "_wrc"}, wr_count, 32'(m_wr));
        chk({tag, "_viol"}, 32'(violation), 32'(m_viol));
    endtask

    task automatic step(input logic c, input logic w, input logic o,
                        input logic u, input logic l,
                        input logic [AW-1:0] a, input logic [15:0] d,
                        input string tag);
        @(negedge clk);
        ce_n = c;
        we_n = w;
        oe_n = o;
        ub_n = u;
        lb_n = l;
        addr = a;
        wdata = d;
        #1 check_dq({tag, "_pre"});
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic u, input logic l,
                      input string tag);
        step(1'b0, 1'b1, 1'b0, u, l, a, 16'h0000, tag);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic u, input logic l,
                      input logic [15:0] d, input string tag);
        step(1'b0, 1'b0, 1'b1, u, l, a, d, tag);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, addr, 16'h0000, "idle");
    endtask

    initial begin
        model_reset();
        #70;
        rst = 1'b1;
        #1 check_all("reset");
        chk("reset_dq", 32'(dq), 32'h0000FFFF);

        wr(5, 1'b0, 1'b0, 16'hBEEF, "wr_beef");
        idle();
        repeat (3) rd(5, 1'b0, 1'b0, "rd_beef");
        chk("beef_data", 32'(dq), 32'h0000BEEF);
        chk("beef_rdc", rd_count, 32'd1);
        chk("beef_wrc", wr_count, 32'd1);
        idle();

        wr(5, 1'b1, 1'b0, 16'h1234, "wr_byte");
        idle();
        repeat (3) rd(5, 1'b0, 1'b0, "rd_byte");
        chk("byte_data", 32'(dq), 32'h0000BE34);
        idle();

        repeat (3) rd(5, 1'b0, 1'b1, "rd_lane");
        chk("lane_data", 32'(dq), 32'h0000BEFF);
        idle();

        wr(6, 1'b0, 1'b0, 16'h6666, "wr_six");
        idle();
        rd(5, 1'b0, 1'b0, "chg0");
        rd(6, 1'b0, 1'b0, "chg1");
        rd(6, 1'b0, 1'b0, "chg2");
        chk("chg_busy", 32'(busy), 32'd1);
        rd(6, 1'b0, 1'b0, "chg3");
        chk("chg_data", 32'(dq), 32'h00006666);
        chk("chg_viol", 32'(violation), 32'(CHECK_ON));
        rd(5, 1'b0, 1'b0, "rv_move");
        idle();

        rd(5, 1'b0, 1'b0, "rst_rd0");
        #2 rst = 1'b0;
        model_reset();
        #1 chk("rst_dq_now", 32'(dq), 32'h0000FFFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdc", rd_count, 32'd0);
        @(negedge clk);
        ce_n = 1'b1;
        we_n = 1'b1;
        oe_n = 1'b1;
        ub_n = 1'b1;
        lb_n = 1'b1;
        rst = 1'b1;
        idle();
        repeat (3) rd(5, 1'b0, 1'b0, "rd_after_rst");
        chk("after_rst_data", 32'(dq), 32'h0000BE34);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic c, w, o, u, l;
            logic [AW-1:0] a;
            logic [15:0] d;
            c = $urandom_range(0, 9) == 0;
            w = $urandom_range(0, 2) != 0;
            o = $urandom_range(0, 3) == 0;
            a = addr;
            u = ub_n;
            l = lb_n;
            if (ce_n || $urandom_range(0, 4) == 0) begin
                a = AW'($urandom_range(0, 7));
                u = $urandom_range(0, 3) == 0;
                l = $urandom_range(0, 3) == 0;
            end
            d = 16'($urandom);
            step(c, w, o, u, l, a, d, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_model.md
# sram_model

Cycle-based behavioural model of the external 256K×16 asynchronous SRAM that sits on the `SRAM_*` pins directly downstream of `SRAM_CTRL`, closing the loop so `testbench` runs the full CPU against real memory timing instead of leaving the SRAM bus unconnected. It stores data with byte-lane masking and applies a configurable read latency. It drives the tri-state data bus only during valid read windows and counts completed accesses. An optional protocol checker flags controller timing violations.

## Interface
- `ADDR_WIDTH`, 18, address bus width; storage depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 16, data bus width; must be 16 because there are two byte lanes.
- `READ_LATENCY`, 2, rising edges from first sampled read request to valid data; legal range is at least 1.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `SRAM_DQ`  inout  16  bidirectional data bus.
- `SRAM_ADDR`  in  18  word address.
- `SRAM_UB_N`  in  1  upper-byte (`[15:8]`) enable, active-low.
- `SRAM_LB_N`  in  1  lower-byte (`[7:0]`) enable, active-low.
- `SRAM_WE_N`  in  1  write enable, active-low.
- `SRAM_CE_N`  in  1  chip enable, active-low.
- `SRAM_OE_N`  in  1  output enable, active-low.
- `rd_count`  out  32  completed reads.
- `wr_count`  out  32  committed writes.
- `busy`  out  1  high while in READ_WAIT.
- `violation`  out  1  sticky protocol-error flag.

## Operation
- All pins are sampled on the rising edge of `clk`.
- Request decode:
  - Write request: `CE_N=0`, `WE_N=0`.
  - Read request: `CE_N=0`, `WE_N=1`, `OE_N=0`.
  - Idle: anything else.
- States: IDLE, READ_WAIT, READ_VALID, WRITE.
- IDLE:
  - On a write request: commit `mem[ADDR]` lanes whose enable is low, increment `wr_count`, go to WRITE.
  - On a read request: go to READ_WAIT, load `cnt = READ_LATENCY-1`.
- WRITE:
  - Each edge with a write request and a changed `ADDR`: commit and count again.
  - Same `ADDR`: rewrite data without counting.
  - No write request: go to IDLE.
- READ_WAIT:
  - If `cnt==0`: go to READ_VALID and increment `rd_count`.
  - Otherwise: decrement `cnt`.
  - `ADDR`, `UB_N` or `LB_N` change: restart READ_WAIT with `cnt = READ_LATENCY-1`.
  - Request dropped: go to IDLE.
- READ_VALID:
  - Holds while the read request is held with the same `ADDR`.
  - `ADDR` change: go to READ_WAIT.
  - Request dropped: go to IDLE.
  - A write request: go to WRITE (committed as in IDLE).
- `SRAM_DQ` drive:
  - READ_WAIT: enabled lanes driven `x`.
  - READ_VALID: enabled lanes driven with `mem[ADDR]`.
  - Disabled lanes, and every other state: high-Z.
- Simultaneous `WE_N=0` and `OE_N=0`: write wins; DQ is not driven.
- Memory is zero-initialised at time 0 only; reset does not clear contents.
- Counters wrap modulo 2^32.

## Timing
- Reset (`rst` low, asynchronous):
  - state IDLE, `cnt` 0;
  - `rd_count`, `wr_count` = 0;
  - `busy` = 0, `violation` = 0;
  - `SRAM_DQ` high-Z immediately, not at the next edge.
- Reset mid-read or mid-write: the access is abandoned. A write already committed at an earlier edge is kept.
- Read latency: data is valid after the READ_LATENCY-th edge following the first sampling edge.
  - `READ_LATENCY=2`: edge0 enters READ_WAIT, edge1 `cnt` reaches 0, edge2 enters READ_VALID and data appears.
- `DQ` updates combinationally from state and `ADDR`. A new address in READ_VALID keeps old-address data until the next edge moves the state to READ_WAIT.
- Write latency is 0 wait cycles. Data is captured on the sampling edge, so a read of the same address issued at the next edge returns new data.

## Configuration
- `SRAM_PROTOCOL_CHECK_EN` defined: the following set `violation` and `$display` the time and cause:
  - `ADDR`, `UB_N` or `LB_N` change during READ_WAIT;
  - a write request with `UB_N=LB_N=1`;
  - simultaneous `WE_N=0` and `OE_N=0`.
- `violation` stays high until reset.
- Not defined: `violation` is tied to 0. Functional behaviour is otherwise identical.

## Test plan
- Reset: hold `rst=0` 70 ns, then release → counts 0, `busy=0`, `violation=0`, `SRAM_DQ=16'hzzzz`.
- Full write then read: write `16'hBEEF` to addr 5 with both lanes enabled, then read addr 5 (`READ_LATENCY=2`):
  - DQ `x` for 2 edges, then `16'hBEEF`;
  - `wr_count=1`, `rd_count=1`.
- Byte write: write `16'h1234` to addr 5 with `UB_N=1`, `LB_N=0`, then read → `16'hBE34`.
- Lane read: read addr 5 with `LB_N=1` → `DQ[15:8]=8'hBE`, `DQ[7:0]` high-Z.
- Address change in READ_WAIT: change addr 5→6 one edge after the read starts:
  - READ_WAIT restarts; valid data appears 2 edges after the change;
  - `violation=1` with the macro, 0 without.
- Reset mid-read: pull `rst` low during READ_WAIT → DQ high-Z at once, state IDLE. After release, reading addr 5 returns `16'hBE34`.
